// File: rtl/wbm_arbiter.sv
// ---------------------------------------------------------------------------
// wbm_arbiter
//
// Two-master to one-bus arbiter for the 16-bit Wishbone-style memory port.
// The instruction fetch master (I) and the load/store master (D) each post
// single-cycle strobe requests. Each master has one request latch. The
// arbiter issues the latched requests one at a time on the shared bus and
// returns a one-cycle acknowledge and the read data to the master that
// asked for the transfer.
//
// Ports
//   clk_i, reset_i         core clock (rising edge), async active-low reset
//   iadr_i, istb_i         fetch request: address, one-cycle strobe
//   iack_o, idat_o         fetch completion pulse and read data
//   dadr_i, ddat_i, dwe_i  LSU request: address, write data, write enable
//   dstb_i                 LSU request strobe, one cycle
//   dack_o, ddat_o         LSU completion pulse and read data
//   wbmadr_o, wbmdat_o,    bus address, write data, write enable,
//   wbmwe_o, wbmstb_o      one-cycle strobe per transfer
//   wbmack_i, wbmdat_i     bus acknowledge and read data
//   state_dbg              current arbiter state (IDLE=0, OWN_I=1, OWN_D=2)
//
// Handshake, the same on both the upstream and downstream sides:
//   A request is a strobe that is high for one cycle, with its address,
//   data and we valid in that cycle. Nothing is held high until it is
//   accepted. The reply is a single-cycle ack that arrives any number of
//   cycles later. The ack may also arrive in the strobe cycle itself. Read
//   data is valid in the ack cycle. On the master side, a strobe that cannot
//   be queued is silently dropped. A strobe cannot be queued when the
//   master's latch is full or when its own transfer is still waiting for an
//   ack. A bus ack that arrives while no transfer is outstanding is ignored.
// ---------------------------------------------------------------------------
module wbm_arbiter (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic [63:0] iadr_i,
    input  logic        istb_i,
    output logic        iack_o,
    output logic [15:0] idat_o,

    input  logic [63:0] dadr_i,
    input  logic [15:0] ddat_i,
    input  logic        dwe_i,
    input  logic        dstb_i,
    output logic        dack_o,
    output logic [15:0] ddat_o,

    output logic [63:0] wbmadr_o,
    output logic [15:0] wbmdat_o,
    output logic        wbmwe_o,
    output logic        wbmstb_o,
    input  logic        wbmack_i,
    input  logic [15:0] wbmdat_i,

    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t state;

    // Request latches. The fetch latch carries only an address because
    // fetches are always reads with zero write data.
    logic        i_pend;
    logic [63:0] i_adr;
    logic        d_pend;
    logic [63:0] d_adr;
    logic [15:0] d_dat;
    logic        d_we;

    // 1 when D received the most recent grant. Reset leaves it at I, so D
    // wins the first tie.
    logic        last_d;

    logic        i_accept;
    logic        d_accept;
    logic        grant_i;
    logic        grant_d;

    // A master's own transfer stops blocking new strobes on its ack edge.
    // A strobe sampled on that edge is therefore queued.
    always_comb begin
        i_accept = 1'b0;
        d_accept = 1'b0;
        i_accept = istb_i && !i_pend && !((state == OWN_I) && !wbmack_i);
        d_accept = dstb_i && !d_pend && !((state == OWN_D) && !wbmack_i);
    end

    // On a tie, the master that did not win last time gets the bus.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            grant_i = i_pend && (!d_pend || last_d);
            grant_d = d_pend && (!i_pend || !last_d);
        end
    end

    // Request latches. A latch never accepts and is granted on the same
    // edge: accepting needs an empty latch, and a grant needs a full one.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            i_pend <= 1'b0;
            i_adr  <= 64'h0;
            d_pend <= 1'b0;
            d_adr  <= 64'h0;
            d_dat  <= 16'h0;
            d_we   <= 1'b0;
        end else begin
            if (i_accept) begin
                i_pend <= 1'b1;
                i_adr  <= iadr_i;
            end else if (grant_i) begin
                i_pend <= 1'b0;
            end

            if (d_accept) begin
                d_pend <= 1'b1;
                d_adr  <= dadr_i;
                d_dat  <= ddat_i;
                d_we   <= dwe_i;
            end else if (grant_d) begin
                d_pend <= 1'b0;
            end
        end
    end

    // Arbiter FSM and all registered outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            wbmadr_o <= 64'h0;
            wbmdat_o <= 16'h0;
            wbmwe_o  <= 1'b0;
            wbmstb_o <= 1'b0;
            iack_o   <= 1'b0;
            idat_o   <= 16'h0;
            dack_o   <= 1'b0;
            ddat_o   <= 16'h0;
        end else begin
            // Strobe and both acks are single-cycle pulses.
            wbmstb_o <= 1'b0;
            iack_o   <= 1'b0;
            dack_o   <= 1'b0;

            case (state)
                IDLE: begin
                    // A bus ack seen here has no transfer to complete, so
                    // it is ignored.
                    if (grant_d) begin
                        state    <= OWN_D;
                        last_d   <= 1'b1;
                        wbmstb_o <= 1'b1;
                        wbmadr_o <= d_adr;
                        wbmdat_o <= d_dat;
                        wbmwe_o  <= d_we;
                    end else if (grant_i) begin
                        state    <= OWN_I;
                        last_d   <= 1'b0;
                        wbmstb_o <= 1'b1;
                        wbmadr_o <= i_adr;
                        wbmdat_o <= 16'h0;
                        wbmwe_o  <= 1'b0;
                    end
                end

                OWN_I: begin
                    if (wbmack_i) begin
                        state   <= IDLE;
                        wbmwe_o <= 1'b0;
                        iack_o  <= 1'b1;
                        idat_o  <= wbmdat_i;
                    end
                end

                OWN_D: begin
                    if (wbmack_i) begin
                        state   <= IDLE;
                        wbmwe_o <= 1'b0;
                        dack_o  <= 1'b1;
                        ddat_o  <= wbmdat_i;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_wbm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wbm_arbiter
//
// Directed bench for wbm_arbiter. A transaction-level model tracks each
// master's queued request and the current bus owner. One compare process
// checks every DUT output against that model on each falling edge.
// Directed sections add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_wbm_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i  = 1'b0;
    logic [63:0] iadr_i   = 64'h0;
    logic        istb_i   = 1'b0;
    logic [63:0] dadr_i   = 64'h0;
    logic [15:0] ddat_i   = 16'h0;
    logic        dwe_i    = 1'b0;
    logic        dstb_i   = 1'b0;
    logic        wbmack_i = 1'b0;
    logic [15:0] wbmdat_i = 16'h0;

    logic        iack_o;
    logic [15:0] idat_o;
    logic        dack_o;
    logic [15:0] ddat_o;
    logic [63:0] wbmadr_o;
    logic [15:0] wbmdat_o;
    logic        wbmwe_o;
    logic        wbmstb_o;
    logic [1:0]  state_dbg;

    wbm_arbiter dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .iadr_i    (iadr_i),
        .istb_i    (istb_i),
        .iack_o    (iack_o),
        .idat_o    (idat_o),
        .dadr_i    (dadr_i),
        .ddat_i    (ddat_i),
        .dwe_i     (dwe_i),
        .dstb_i    (dstb_i),
        .dack_o    (dack_o),
        .ddat_o    (ddat_o),
        .wbmadr_o  (wbmadr_o),
        .wbmdat_o  (wbmdat_o),
        .wbmwe_o   (wbmwe_o),
        .wbmstb_o  (wbmstb_o),
        .wbmack_i  (wbmack_i),
        .wbmdat_i  (wbmdat_i),
        .state_dbg (state_dbg)
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each master is 0 (fetch) or 1 (LSU). owner is -1 while the bus is
    // free. A queued request is a flag plus its captured payload.
    bit          m_ipend  = 1'b0;
    logic [63:0] m_iadr   = 64'h0;
    bit          m_dpend  = 1'b0;
    logic [63:0] m_dadr   = 64'h0;
    logic [15:0] m_ddat   = 16'h0;
    bit          m_dwe    = 1'b0;
    int          m_owner  = -1;
    bit          m_last_d = 1'b0;

    logic        exp_stb  = 1'b0;
    logic [63:0] exp_adr  = 64'h0;
    logic [15:0] exp_wdat = 16'h0;
    logic        exp_we   = 1'b0;
    logic        exp_iack = 1'b0;
    logic [15:0] exp_idat = 16'h0;
    logic        exp_dack = 1'b0;
    logic [15:0] exp_ddat = 16'h0;

    // Which master the next free bus cycle goes to. A tie goes to whoever
    // did not win last time.
    function automatic int pick(input bit pi, input bit pd, input bit last_was_d);
        if (pi && pd) return last_was_d ? 0 : 1;
        if (pd) return 1;
        if (pi) return 0;
        return -1;
    endfunction

    int m_pick;
    bit m_iacc;
    bit m_dacc;
    assign m_pick = pick(m_ipend, m_dpend, m_last_d);
    // A master is busy while its request is queued, or while its own
    // transfer is outstanding and not being acked this edge.
    assign m_iacc = istb_i && !m_ipend && !(m_owner == 0 && !wbmack_i);
    assign m_dacc = dstb_i && !m_dpend && !(m_owner == 1 && !wbmack_i);

    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            m_ipend  <= 1'b0;
            m_dpend  <= 1'b0;
            m_owner  <= -1;
            m_last_d <= 1'b0;
            exp_stb  <= 1'b0;
            exp_adr  <= 64'h0;
            exp_wdat <= 16'h0;
            exp_we   <= 1'b0;
            exp_iack <= 1'b0;
            exp_idat <= 16'h0;
            exp_dack <= 1'b0;
            exp_ddat <= 16'h0;
        end else begin
            exp_stb  <= 1'b0;
            exp_iack <= 1'b0;
            exp_dack <= 1'b0;
            if (m_owner == -1) begin
                if (m_pick == 0) begin
                    m_owner  <= 0;
                    m_last_d <= 1'b0;
                    exp_stb  <= 1'b1;
                    exp_adr  <= m_iadr;
                    exp_wdat <= 16'h0;
                    exp_we   <= 1'b0;
                end else if (m_pick == 1) begin
                    m_owner  <= 1;
                    m_last_d <= 1'b1;
                    exp_stb  <= 1'b1;
                    exp_adr  <= m_dadr;
                    exp_wdat <= m_ddat;
                    exp_we   <= m_dwe;
                end
            end else if (wbmack_i) begin
                m_owner <= -1;
                exp_we  <= 1'b0;
                if (m_owner == 0) begin
                    exp_iack <= 1'b1;
                    exp_idat <= wbmdat_i;
                end else begin
                    exp_dack <= 1'b1;
                    exp_ddat <= wbmdat_i;
                end
            end

            if (m_iacc) begin
                m_ipend <= 1'b1;
                m_iadr  <= iadr_i;
            end else if (m_owner == -1 && m_pick == 0) begin
                m_ipend <= 1'b0;
            end

            if (m_dacc) begin
                m_dpend <= 1'b1;
                m_dadr  <= dadr_i;
                m_ddat  <= ddat_i;
                m_dwe   <= dwe_i;
            end else if (m_owner == -1 && m_pick == 1) begin
                m_dpend <= 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("wbmstb_o", 64'(wbmstb_o), 64'(exp_stb));
        chk("wbmadr_o", wbmadr_o, exp_adr);
        chk("wbmdat_o", 64'(wbmdat_o), 64'(exp_wdat));
        chk("wbmwe_o",  64'(wbmwe_o),  64'(exp_we));
        chk("iack_o",   64'(iack_o),   64'(exp_iack));
        chk("idat_o",   64'(idat_o),   64'(exp_idat));
        chk("dack_o",   64'(dack_o),   64'(exp_dack));
        chk("ddat_o",   64'(ddat_o),   64'(exp_ddat));
        chk("busy",     64'(state_dbg != 2'd0), 64'(m_owner != -1));
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        step(2);
        reset_i = 1'b1;
    endtask

    task automatic d_req(input logic [63:0] adr, input logic [15:0] dat, input logic we);
        dadr_i = adr;
        ddat_i = dat;
        dwe_i  = we;
        dstb_i = 1'b1;
        step(1);
        dstb_i = 1'b0;
        // Scribble the inputs to show the latch ignores them afterwards.
        dadr_i = 64'hFFFF_FFFF_FFFF_FFFF;
        ddat_i = 16'hFFFF;
        dwe_i  = 1'b0;
    endtask

    task automatic i_req(input logic [63:0] adr);
        iadr_i = adr;
        istb_i = 1'b1;
        step(1);
        istb_i = 1'b0;
        iadr_i = 64'hFFFF;
    endtask

    // Drive one cycle of bus ack. Returns on the falling edge after the
    // sampling edge, where the master-side ack is visible.
    task automatic ack_bus(input logic [15:0] d);
        wbmack_i = 1'b1;
        wbmdat_i = d;
        step(1);
        wbmack_i = 1'b0;
        wbmdat_i = 16'($urandom);
    endtask

    // Wait, with a cycle budget, for the next bus strobe and check its payload.
    task automatic wait_grant(input string name, input logic [63:0] adr,
                              input logic [15:0] dat, input logic we);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 16 && !found; n++) begin
            @(negedge clk);
            if (wbmstb_o === 1'b1) found = 1'b1;
        end
        chk({name, " strobe"}, 64'(found), 64'(1'b1));
        if (found) begin
            chk({name, " adr"}, wbmadr_o, adr);
            chk({name, " dat"}, 64'(wbmdat_o), 64'(dat));
            chk({name, " we"},  64'(wbmwe_o),  64'(we));
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset with random inputs: the compare process expects all zeros.
        reset_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            iadr_i   = {32'($urandom), 32'($urandom)};
            istb_i   = 1'($urandom_range(0, 1));
            dadr_i   = {32'($urandom), 32'($urandom)};
            ddat_i   = 16'($urandom);
            dwe_i    = 1'($urandom_range(0, 1));
            dstb_i   = 1'($urandom_range(0, 1));
            wbmack_i = 1'($urandom_range(0, 1));
            wbmdat_i = 16'($urandom);
        end
        step(1);
        chk("reset stb", 64'(wbmstb_o), 64'h0);
        chk("reset adr", wbmadr_o, 64'h0);
        istb_i = 1'b0; dstb_i = 1'b0; wbmack_i = 1'b0; dwe_i = 1'b0;
        step(1);
        reset_i = 1'b1;
        step(2);

        // LSU write.
        d_req(64'h1122334455667788, 16'h1100, 1'b1);
        wait_grant("lsu write", 64'h1122334455667788, 16'h1100, 1'b1);
        step(1);
        chk("lsu write stb drop", 64'(wbmstb_o), 64'h0);
        chk("lsu write adr hold", wbmadr_o, 64'h1122334455667788);
        ack_bus(16'hDEAD);
        chk("lsu write dack", 64'(dack_o), 64'h1);
        chk("lsu write ddat", 64'(ddat_o), 64'hDEAD);
        chk("lsu write iack", 64'(iack_o), 64'h0);
        step(1);
        chk("lsu write dack end", 64'(dack_o), 64'h0);
        chk("lsu write ddat hold", 64'(ddat_o), 64'hDEAD);
        chk("lsu write we clr", 64'(wbmwe_o), 64'h0);
        chk("lsu write adr keep", wbmadr_o, 64'h1122334455667788);

        // Simultaneous strobes after a fresh reset: D wins the first tie.
        do_reset();
        step(1);
        iadr_i = 64'h1000; istb_i = 1'b1;
        dadr_i = 64'h2000; ddat_i = 16'h0; dwe_i = 1'b0; dstb_i = 1'b1;
        step(1);
        istb_i = 1'b0; dstb_i = 1'b0;
        wait_grant("tie1 d", 64'h2000, 16'h0, 1'b0);
        step(1);
        ack_bus(16'hAAAA);
        chk("tie1 dack", 64'(dack_o), 64'h1);
        chk("tie1 no iack", 64'(iack_o), 64'h0);
        step(1);
        chk("tie1 i next", 64'(wbmstb_o), 64'h1);
        chk("tie1 i adr", wbmadr_o, 64'h1000);
        ack_bus(16'h5A5A);
        chk("tie1 iack", 64'(iack_o), 64'h1);
        chk("tie1 idat", 64'(idat_o), 64'h5A5A);
        step(1);

        // A lone D transfer leaves D as last winner, so the next tie goes to I.
        d_req(64'h2222, 16'h0202, 1'b1);
        wait_grant("solo d", 64'h2222, 16'h0202, 1'b1);
        ack_bus(16'h0001);
        step(1);
        iadr_i = 64'h1100; istb_i = 1'b1;
        dadr_i = 64'h2100; ddat_i = 16'h0303; dwe_i = 1'b1; dstb_i = 1'b1;
        step(1);
        istb_i = 1'b0; dstb_i = 1'b0;
        wait_grant("tie2 i", 64'h1100, 16'h0, 1'b0);
        ack_bus(16'h1111);
        chk("tie2 iack", 64'(iack_o), 64'h1);
        wait_grant("tie2 d", 64'h2100, 16'h0303, 1'b1);
        ack_bus(16'h2222);
        chk("tie2 dack", 64'(dack_o), 64'h1);
        step(1);

        // Queued fetch behind an in-flight D. A second D strobe is dropped.
        d_req(64'h3000, 16'h5555, 1'b1);
        wait_grant("queue d", 64'h3000, 16'h5555, 1'b1);
        i_req(64'h4000);
        d_req(64'hAAAA, 16'h7777, 1'b1);
        step(2);
        ack_bus(16'hBEEF);
        chk("queue dack", 64'(dack_o), 64'h1);
        wait_grant("queue i", 64'h4000, 16'h0, 1'b0);
        step(2);
        ack_bus(16'h1234);
        chk("queue iack", 64'(iack_o), 64'h1);
        chk("queue idat", 64'(idat_o), 64'h1234);
        chk("queue ddat hold", 64'(ddat_o), 64'hBEEF);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("dropped d no strobe", 64'(wbmstb_o), 64'h0);
        end

        // Spurious ack in IDLE, then a normal read.
        ack_bus(16'h7777);
        chk("spurious iack", 64'(iack_o), 64'h0);
        chk("spurious dack", 64'(dack_o), 64'h0);
        chk("spurious stb", 64'(wbmstb_o), 64'h0);
        d_req(64'h5000, 16'h0, 1'b0);
        wait_grant("after spurious", 64'h5000, 16'h0, 1'b0);
        ack_bus(16'h4321);
        chk("after spurious dack", 64'(dack_o), 64'h1);
        chk("after spurious ddat", 64'(ddat_o), 64'h4321);
        step(1);

        // Zero-wait bus, plus a D strobe on the ack edge of D's own transfer.
        d_req(64'h6600, 16'h0066, 1'b1);
        wait_grant("zero wait", 64'h6600, 16'h0066, 1'b1);
        wbmack_i = 1'b1; wbmdat_i = 16'h0ABC;
        dadr_i = 64'h8000; ddat_i = 16'h0088; dwe_i = 1'b0; dstb_i = 1'b1;
        step(1);
        wbmack_i = 1'b0; dstb_i = 1'b0;
        chk("zero wait dack", 64'(dack_o), 64'h1);
        chk("zero wait ddat", 64'(ddat_o), 64'h0ABC);
        wait_grant("ack edge strobe", 64'h8000, 16'h0088, 1'b0);
        ack_bus(16'h0808);
        step(1);

        // Mid-transfer reset with D in flight and I queued.
        d_req(64'h6000, 16'h6006, 1'b1);
        wait_grant("pre reset", 64'h6000, 16'h6006, 1'b1);
        i_req(64'h7000);
        #2;
        reset_i = 1'b0;
        #1;
        chk("midrst stb", 64'(wbmstb_o), 64'h0);
        chk("midrst adr", wbmadr_o, 64'h0);
        chk("midrst dat", 64'(wbmdat_o), 64'h0);
        chk("midrst we",  64'(wbmwe_o),  64'h0);
        chk("midrst ddat", 64'(ddat_o), 64'h0);
        chk("midrst idat", 64'(idat_o), 64'h0);
        step(2);
        reset_i = 1'b1;
        ack_bus(16'h9999);
        chk("post rst iack", 64'(iack_o), 64'h0);
        chk("post rst dack", 64'(dack_o), 64'h0);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("post rst no strobe", 64'(wbmstb_o), 64'h0);
        end

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
